// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: shared encodings, widths and request checks for the data-memory controller
package dmem_access_ctrl_pkg;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: req/ack bus between the access controller and the data memory
interface dmem_access_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_rdata, mem_ack);
    modport slave  (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/dmem_access_ctrl_load_align_ext.sv
// load_align_ext: picks the addressed byte/halfword lane of a read word and sign/zero-extends it
module load_align_ext
    import dmem_access_ctrl_pkg::*;
#(
    parameter int WIDTH = DW
) (
    input  logic [WIDTH-1:0] rdata_i,
    input  logic [1:0]       off_i,
    input  logic [1:0]       size_i,
    input  logic             sext_i,
    output logic [WIDTH-1:0] data_o
);
    logic [7:0]  b;
    logic [15:0] h;
    // lane select followed by extension; words pass straight through
    always_comb begin
        b = rdata_i[{off_i, 3'b000} +: 8];
        h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        data_o = size_i == SZ_BYTE ? {{(WIDTH-8){sext_i & b[7]}}, b}
               : size_i == SZ_HALF ? {{(WIDTH-16){sext_i & h[15]}}, h}
               : rdata_i;
    end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: multicycle load/store controller with req/ack memory handshake, alignment and timeout checks
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DW,
    parameter int ADDR_WIDTH = AW,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic [1:0]            Size,
    input  logic                  SignExt,
    output logic [DATA_WIDTH-1:0] DMemOut,
    output logic                  Busy,
    output logic                  Done,
    output logic                  AlignErr,
    output logic                  TimeoutErr,
    dmem_access_ctrl_if.master    mem
);
    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [1:0]            off_q, size_q;
    logic                  sext_q, we_q, req_q;
    logic                  busy_q, done_q, align_q, tmo_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, dout_q, load_d;

    // byte-lane enables and lane-replicated store data for the incoming request
    always_comb begin
        be_d = Size == SZ_BYTE ? 4'b0001 << Addr[1:0] : Size == SZ_HALF ? (Addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_d = Size == SZ_BYTE ? {4{WriteData[7:0]}} : Size == SZ_HALF ? {2{WriteData[15:0]}} : WriteData;
    end

    load_align_ext #(.WIDTH(DATA_WIDTH)) u_align (
        .rdata_i (mem.mem_rdata),
        .off_i   (off_q),
        .size_i  (size_q),
        .sext_i  (sext_q),
        .data_o  (load_d)
    );

    // access FSM; every output is a register so the mux downstream sees clean levels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            align_q <= 1'b0;
            tmo_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            align_q <= 1'b0;
            tmo_q   <= 1'b0;
            case (state_q)
                IDLE: if (MemRead || MemWrite) begin
                    busy_q <= 1'b1;
                    if ((MemRead && MemWrite) || misaligned(Size, Addr[1:0])) begin
                        state_q <= ERR;
                        align_q <= 1'b1;
                    end else begin
                        state_q <= ACCESS;
                        req_q   <= 1'b1;
                        we_q    <= MemWrite;
                        addr_q  <= {Addr[ADDR_WIDTH-1:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        cnt_q   <= '0;
                        off_q   <= Addr[1:0];
                        size_q  <= Size;
                        sext_q  <= SignExt;
                    end
                end
                ACCESS: if (mem.mem_ack) begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    if (!we_q) dout_q <= load_d;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_q <= ERR;
                    tmo_q   <= 1'b1;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DMemOut       = dout_q;
    assign Busy          = busy_q;
    assign Done          = done_q;
    assign AlignErr      = align_q;
    assign TimeoutErr    = tmo_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed table, reset corner case and randomized accesses against a byte-level model
module tb_dmem_access_ctrl;
    localparam int TO = 15;

    typedef struct {
        logic        mr;
        logic        mw;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [1:0]  size;
        logic        sext;
        int          waitc;
        logic [31:0] rdata;
        int          err;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        upd;
        logic [31:0] dout;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, SignExt;
    logic [31:0] Addr, WriteData, DMemOut;
    logic [1:0]  Size;
    logic        Busy, Done, AlignErr, TimeoutErr;
    logic [31:0] ref_dout;
    int          n_chk = 0;
    int          n_fail = 0;
    rec_t        tbl[$];

    dmem_access_ctrl_if mif ();

    dmem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Addr       (Addr),
        .WriteData  (WriteData),
        .Size       (Size),
        .SignExt    (SignExt),
        .DMemOut    (DMemOut),
        .Busy       (Busy),
        .Done       (Done),
        .AlignErr   (AlignErr),
        .TimeoutErr (TimeoutErr),
        .mem        (mif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: access is n bytes wide, lanes computed from byte offsets and replication
    function automatic rec_t model(input rec_t r);
        int nb, lo;
        logic [63:0] mask, v;
        nb = (r.size == 2'd3) ? 0 : (1 << r.size);
        lo = int'(r.addr[1:0]);
        if ((r.mr && r.mw) || nb == 0 || (lo % nb) != 0) r.err = 1;
        else if (r.waitc < 0) r.err = 2;
        else r.err = 0;
        r.be = 4'(((1 << nb) - 1) << lo);
        for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = r.wd[8*(i % (nb == 0 ? 1 : nb)) +: 8];
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v = ({32'd0, r.rdata} >> (8 * lo)) & mask;
        if (r.sext && nb > 0 && nb < 4 && v[8*nb-1]) v = v | ~mask;
        r.upd = r.mr && !r.mw && r.err == 0;
        r.dout = v[31:0];
        return r;
    endfunction

    // one request from the IDLE cycle through the return to IDLE; enters and leaves at posedge+1
    task automatic run(input rec_t r, input string tag);
        int n;
        MemRead = r.mr; MemWrite = r.mw; Addr = r.addr; WriteData = r.wd; Size = r.size; SignExt = r.sext;
        mif.mem_ack = 1'b0;
        @(negedge clk);
        chk({tag, " busy0"}, 32'(Busy), 32'd0);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; Addr = $urandom; WriteData = $urandom;
        Size = 2'($urandom_range(0, 3)); SignExt = 1'($urandom_range(0, 1));
        if (r.err == 1) begin
            @(negedge clk);
            chk({tag, " alignerr"}, 32'(AlignErr), 32'd1);
            chk({tag, " busy"}, 32'(Busy), 32'd1);
            chk({tag, " noreq"}, 32'(mif.mem_req), 32'd0);
            chk({tag, " nodone"}, 32'(Done), 32'd0);
        end else begin
            n = r.waitc < 0 ? TO : r.waitc + 1;
            for (int k = 0; k < n; k++) begin
                mif.mem_ack = (k == r.waitc);
                mif.mem_rdata = (k == r.waitc) ? r.rdata : $urandom;
                @(negedge clk);
                chk($sformatf("%s req%0d", tag, k), 32'(mif.mem_req), 32'd1);
                if (k == 0) begin
                    chk({tag, " addr"}, mif.mem_addr, {r.addr[31:2], 2'b00});
                    chk({tag, " be"}, 32'(mif.mem_be), 32'(r.be));
                    chk({tag, " we"}, 32'(mif.mem_we), 32'(r.mw));
                    if (r.mw) chk({tag, " wdata"}, mif.mem_wdata, r.wdata);
                end
                @(posedge clk); #1;
            end
            mif.mem_ack = 1'($urandom_range(0, 1));
            mif.mem_rdata = $urandom;
            @(negedge clk);
            if (r.err == 2) begin
                chk({tag, " tmoerr"}, 32'(TimeoutErr), 32'd1);
                chk({tag, " nodone"}, 32'(Done), 32'd0);
            end else begin
                chk({tag, " done"}, 32'(Done), 32'd1);
            end
            chk({tag, " reqoff"}, 32'(mif.mem_req), 32'd0);
            chk({tag, " busy"}, 32'(Busy), 32'd1);
            if (r.upd) ref_dout = r.dout;
            chk({tag, " dout"}, DMemOut, ref_dout);
        end
        @(posedge clk); #1;
        mif.mem_ack = 1'b0;
        @(negedge clk);
        chk({tag, " idle"}, {28'd0, Busy, Done, AlignErr, TimeoutErr}, 32'd0);
        chk({tag, " dout_hold"}, DMemOut, ref_dout);
        @(posedge clk); #1;
    endtask

    initial begin
        rec_t r;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0; Size = '0; SignExt = 1'b0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0; ref_dout = '0;
        tbl.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0, 32'hDEADBEEF, 0, 4'hF, 32'h0, 1'b1, 32'hDEADBEEF});
        tbl.push_back('{1'b1, 1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 3, 32'h80123456, 0, 4'h8, 32'h0, 1'b1, 32'hFFFFFF80});
        tbl.push_back('{1'b0, 1'b1, 32'h102, 32'h1234ABCD, 2'd1, 1'b0, 1, 32'h0, 0, 4'hC, 32'hABCDABCD, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 0, 32'h0, 1, 4'h0, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b1, 32'h100, 32'h0, 2'd2, 1'b0, 0, 32'h0, 1, 4'h0, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 0, 32'h0, 1, 4'h0, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0, -1, 32'h0, 2, 4'hF, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h106, 32'h0, 2'd1, 1'b0, 1, 32'h87654321, 0, 4'hC, 32'h0, 1'b1, 32'h00008765});
        tbl.push_back('{1'b0, 1'b1, 32'h0FD, 32'h000000A5, 2'd0, 1'b0, 0, 32'h0, 0, 4'h2, 32'hA5A5A5A5, 1'b0, 32'h0});
        tbl.push_back('{1'b1, 1'b0, 32'h101, 32'h0, 2'd0, 1'b1, 2, 32'h00007F00, 0, 4'h2, 32'h0, 1'b1, 32'h0000007F});
        @(posedge clk);
        @(negedge clk);
        chk("reset flags", {27'd0, Busy, Done, AlignErr, TimeoutErr, mif.mem_req}, 32'd0);
        chk("reset we_be", {27'd0, mif.mem_we, mif.mem_be}, 32'd0);
        chk("reset addr", mif.mem_addr, 32'd0);
        chk("reset wdata", mif.mem_wdata, 32'd0);
        chk("reset dout", DMemOut, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));
        MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h300; Size = 2'd2; SignExt = 1'b0; mif.mem_ack = 1'b0;
        @(posedge clk); #1;
        MemRead = 1'b0;
        @(negedge clk);
        chk("rst pre req", 32'(mif.mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst async req", 32'(mif.mem_req), 32'd0);
        chk("rst async busy", 32'(Busy), 32'd0);
        chk("rst async dout", DMemOut, 32'd0);
        ref_dout = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst no done", {30'd0, Done, Busy}, 32'd0);
        @(posedge clk); #1;
        run(tbl[0], "post_rst");
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 5);
            r.mr = (sel <= 2) || (sel == 5);
            r.mw = (sel >= 3);
            r.size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r.addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (r.size == 2'd1) r.addr[0] = 1'b0;
                if (r.size == 2'd2) r.addr[1:0] = 2'b00;
            end
            r.wd = $urandom;
            r.sext = 1'($urandom_range(0, 1));
            r.waitc = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            r.rdata = $urandom;
            run(model(r), $sformatf("rnd%0d", i));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
